// File: rtl/mii_tx_framer.sv
// mii_tx_framer
// Transmit-side Ethernet MAC framer driving the MII transmit pins.
// A frame request captures a destination MAC and ethertype. The framer
// then sends preamble/SFD, DA, SA, type and the payload nibble stream.
// Zero padding brings the payload up to the minimum frame size. The
// frame ends with the CRC-32 FCS, followed by the inter-frame gap.
//
// Ports:
//   clk        MII transmit clock (rising edge), single clock domain
//   rst        synchronous active-high reset
//   start      single-cycle frame request, honoured only while busy=0
//   dst_mac    destination address, captured on an accepted start
//   ethertype  type field, captured on an accepted start
//   din        payload nibble, low nibble of each byte first
//   din_valid  din is valid
//   din_last   marks the final payload nibble
//   din_ready  framer takes din this cycle (PAYLOAD state only)
//   txd        MII transmit data
//   txctl      MII transmit enable
//   busy       frame or inter-frame gap in progress
//   done       pulse on the cycle the last FCS nibble is driven
//   err        pulse on abort (underrun or overlength)
module mii_tx_framer #(
    parameter logic [47:0] MAC_ADDR            = 48'h696969696969,
    parameter int          IFG_NIBBLES         = 24,
    parameter int          MIN_PAYLOAD_NIBBLES = 92,
    parameter int          MAX_PAYLOAD_NIBBLES = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] dst_mac,
    input  logic [15:0] ethertype,
    input  logic [3:0]  din,
    input  logic        din_valid,
    input  logic        din_last,
    output logic        din_ready,
    output logic [3:0]  txd,
    output logic        txctl,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [47:0] SA_ADDR  = MAC_ADDR;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_PREAMBLE = 4'd1;
    localparam logic [3:0] ST_DA       = 4'd2;
    localparam logic [3:0] ST_SA       = 4'd3;
    localparam logic [3:0] ST_TYPE     = 4'd4;
    localparam logic [3:0] ST_PAYLOAD  = 4'd5;
    localparam logic [3:0] ST_PAD      = 4'd6;
    localparam logic [3:0] ST_FCS      = 4'd7;
    localparam logic [3:0] ST_IFG      = 4'd8;
    localparam logic [3:0] ST_ABORT    = 4'd9;

    logic [3:0]  state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;          // nibble/cycle index within a state
    logic [15:0] pay_cnt_reg, pay_cnt_next;  // payload + pad nibbles sent
    logic [31:0] crc_reg;
    logic [47:0] dst_reg, dst_next;
    logic [15:0] type_reg, type_next;

    logic        crc_init;
    logic        crc_en;
    logic [15:0] pay_inc;
    logic        pad_done;
    logic [5:0]  addr_off;
    logic [3:0]  type_off;
    logic [4:0]  fcs_off;
    logic [31:0] crc_inv;
    logic [31:0] crc_chain [0:4];

    assign pay_inc  = pay_cnt_reg + 16'd1;
    // Frame body is long enough and byte aligned once this nibble is out.
    assign pad_done = (pay_inc >= 16'(MIN_PAYLOAD_NIBBLES)) && !pay_inc[0];

    // Fields go out most-significant byte first, low nibble of each byte
    // first: nibble n lives at bit offset (top byte - 8*(n/2)) + 4*(n%2).
    assign addr_off = 6'd40 - {cnt_reg[3:1], 3'b000} + {3'b000, cnt_reg[0], 2'b00};
    assign type_off = 4'd8 - {cnt_reg[1], 3'b000} + {1'b0, cnt_reg[0], 2'b00};
    assign fcs_off  = {cnt_reg[2:0], 2'b00};
    assign crc_inv  = ~crc_reg;

    assign busy = (state_reg != ST_IDLE);

    // Four reflected CRC-32 steps per cycle over the nibble on txd, LSB first.
    assign crc_chain[0] = crc_reg;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_crc_bit
            assign crc_chain[gi+1] = {1'b0, crc_chain[gi][31:1]} ^
                                     ((crc_chain[gi][0] ^ txd[gi]) ? CRC_POLY : 32'h0);
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pay_cnt_next = pay_cnt_reg;
        dst_next     = dst_reg;
        type_next    = type_reg;
        txd          = 4'h0;
        txctl        = 1'b0;
        din_ready    = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        crc_init     = 1'b0;
        crc_en       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    dst_next     = dst_mac;
                    type_next    = ethertype;
                    cnt_next     = 16'd0;
                    pay_cnt_next = 16'd0;
                    state_next   = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                txctl    = 1'b1;
                crc_init = 1'b1;
                txd      = (cnt_reg == 16'd15) ? 4'hD : 4'h5;
                if (cnt_reg == 16'd15) begin
                    cnt_next   = 16'd0;
                    state_next = ST_DA;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_DA: begin
                txctl  = 1'b1;
                crc_en = 1'b1;
                txd    = dst_reg[addr_off +: 4];
                if (cnt_reg == 16'd11) begin
                    cnt_next   = 16'd0;
                    state_next = ST_SA;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_SA: begin
                txctl  = 1'b1;
                crc_en = 1'b1;
                txd    = SA_ADDR[addr_off +: 4];
                if (cnt_reg == 16'd11) begin
                    cnt_next   = 16'd0;
                    state_next = ST_TYPE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_TYPE: begin
                txctl  = 1'b1;
                crc_en = 1'b1;
                txd    = type_reg[type_off +: 4];
                if (cnt_reg == 16'd3) begin
                    cnt_next   = 16'd0;
                    state_next = ST_PAYLOAD;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_PAYLOAD: begin
                txctl     = 1'b1;
                din_ready = 1'b1;
                if (!din_valid) begin
                    state_next = ST_ABORT;          // underrun
                end else if (pay_cnt_reg == 16'(MAX_PAYLOAD_NIBBLES)) begin
                    state_next = ST_ABORT;          // overlength, nibble dropped
                end else begin
                    txd          = din;
                    crc_en       = 1'b1;
                    pay_cnt_next = pay_inc;
                    if (din_last) begin
                        cnt_next   = 16'd0;
                        state_next = pad_done ? ST_FCS : ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                txctl        = 1'b1;
                crc_en       = 1'b1;
                pay_cnt_next = pay_inc;
                if (pad_done) begin
                    cnt_next   = 16'd0;
                    state_next = ST_FCS;
                end
            end
            ST_FCS: begin
                txctl = 1'b1;
                txd   = crc_inv[fcs_off +: 4];
                if (cnt_reg == 16'd7) begin
                    done       = 1'b1;
                    cnt_next   = 16'd0;
                    state_next = ST_IFG;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_IFG: begin
                if (cnt_reg == 16'(IFG_NIBBLES - 1)) begin
                    cnt_next   = 16'd0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_ABORT: begin
                err        = 1'b1;
                cnt_next   = 16'd0;
                state_next = ST_IFG;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 16'd0;
            pay_cnt_reg <= 16'd0;
            crc_reg     <= 32'hFFFFFFFF;
            dst_reg     <= 48'd0;
            type_reg    <= 16'd0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pay_cnt_reg <= pay_cnt_next;
            dst_reg     <= dst_next;
            type_reg    <= type_next;
            if (crc_init) begin
                crc_reg <= 32'hFFFFFFFF;
            end else if (crc_en) begin
                crc_reg <= crc_chain[4];
            end
        end
    end

endmodule

// File: tb/tb_mii_tx_framer.sv
// tb_mii_tx_framer
// Self-checking bench for mii_tx_framer. A table of frame scenarios
// (normal, padding boundaries, underrun, overlength) is applied in a loop.
// Hand-written sequences cover reset mid-frame and back-to-back starts.
// Randomized frames follow. Every captured frame is compared against a
// byte-level reference model of the wire format, and CRC residues are
// checked over DA..FCS.
module tb_mii_tx_framer;

    localparam logic [47:0] MAC  = 48'h696969696969;
    localparam logic [31:0] POLY = 32'hEDB88320;
    localparam int          MAXP = 3000;
    localparam int          IFG  = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [47:0] dst_mac;
    logic [15:0] ethertype;
    logic [3:0]  din;
    logic        din_valid;
    logic        din_last;
    logic        din_ready;
    logic [3:0]  txd;
    logic        txctl;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    mii_tx_framer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dst_mac   (dst_mac),
        .ethertype (ethertype),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_ready (din_ready),
        .txd       (txd),
        .txctl     (txctl),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [47:0] dst;
        logic [15:0] et;
        int          n_pay;        // nibbles offered by the bench
        int          underrun_at;  // index where din_valid drops, -1 none
        int          inject_at;    // cycle of a start pulse while busy, -1 none
        bit          counting;     // payload 1,2,3.. instead of random
        int          exp_tx;       // txctl-high cycles
        int          exp_ready;    // din_ready-high cycles
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[8];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  pay_q[$];
    logic [3:0]  exp_q[$];
    logic [3:0]  cap_q[$];
    time         last_tx_time = 0;
    int          last_gap = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference wire image built from bytes: preamble/SFD, header bytes
    // (MSB byte first, each byte low nibble first), payload, zero pad to the
    // 46-byte minimum and whole bytes, then FCS = ~CRC LSB nibble first.
    function automatic void build_expected(input logic [47:0] dst, input logic [15:0] et,
                                           input int n);
        logic [7:0]  hdr[$];
        logic [3:0]  body[$];
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        exp_q.delete();
        repeat (15) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        for (int i = 5; i >= 0; i--) hdr.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) hdr.push_back(MAC[8*i +: 8]);
        hdr.push_back(et[15:8]);
        hdr.push_back(et[7:0]);
        foreach (hdr[i]) begin
            body.push_back(hdr[i][3:0]);
            body.push_back(hdr[i][7:4]);
        end
        for (int i = 0; i < n; i++) body.push_back(pay_q[i]);
        while ((body.size() - 28) < 92 || (body.size() % 2) != 0) body.push_back(4'h0);
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < body.size(); i += 2) begin
            b   = {body[i+1], body[i]};
            crc = crc ^ {24'h0, b};
            repeat (8) crc = crc[0] ? ((crc >> 1) ^ POLY) : (crc >> 1);
        end
        foreach (body[i]) exp_q.push_back(body[i]);
        fcs = ~crc;
        for (int k = 0; k < 8; k++) exp_q.push_back(fcs[4*k +: 4]);
    endfunction

    function automatic logic [31:0] residue();
        logic [31:0] crc = 32'hFFFFFFFF;
        logic [3:0]  nib;
        for (int i = 16; i < cap_q.size(); i++) begin
            nib = cap_q[i];
            for (int bt = 0; bt < 4; bt++)
                crc = (crc[0] ^ nib[bt]) ? ((crc >> 1) ^ POLY) : (crc >> 1);
        end
        return crc;
    endfunction

    // Issues start at the current (negedge-phase) time, then services the
    // payload port and monitors the pins once per cycle until busy falls.
    task automatic run_frame(input string tag, input logic [47:0] dst, input logic [15:0] et,
                             input int n_pay, input int underrun_at, input int inject_at,
                             input int exp_tx, input int exp_ready, input int exp_done,
                             input int exp_err);
        int idx = 0, ready_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
        int ifg_cnt = 0, done_at = -1, k = 0, mism = -1, cmp_len;
        bit seen_busy = 0, seen_tx = 0, prev_fault = 0, fault, finished = 0;
        cap_q.delete();
        dst_mac   = dst;
        ethertype = et;
        start     = 1'b1;
        while (!finished) begin
            @(negedge clk);
            start = 1'b0;
            if (k == inject_at) begin
                start     = 1'b1;
                dst_mac   = ~dst;
                ethertype = ~et;
            end
            if (idx < n_pay && idx != underrun_at) begin
                din_valid = 1'b1;
                din       = pay_q[idx];
                din_last  = (idx == n_pay - 1);
            end else begin
                din_valid = 1'b0;
                din       = 4'($urandom);
                din_last  = 1'b0;
            end
            #1;
            if (k == 0) check({tag, ".first_nibble"}, {txctl, txd}, 5'h15);
            if (busy) seen_busy = 1;
            if (prev_fault) check({tag, ".abort_next"}, {txctl, err}, 2'b01);
            fault      = din_ready && (!din_valid || idx == MAXP);
            prev_fault = fault;
            if (txctl) begin
                if (!seen_tx) last_gap = int'(($time - last_tx_time) / 10) - 1;
                seen_tx = 1;
                cap_q.push_back(txd);
                last_tx_time = $time;
            end else if (busy && seen_tx && !err) begin
                ifg_cnt++;
            end
            if (din_ready) ready_cnt++;
            if (done) begin
                done_cnt++;
                done_at = cap_q.size();
            end
            if (err) err_cnt++;
            if (done && err) both_cnt++;
            if (din_ready && din_valid && !fault) idx++;
            k++;
            if (seen_busy && !busy) finished = 1;
            if (k > 4000) begin
                check({tag, ".busy_bounded"}, busy, 0);
                finished = 1;
            end
        end
        din_valid = 1'b0;
        din_last  = 1'b0;

        check({tag, ".txctl_cycles"}, cap_q.size(), exp_tx);
        check({tag, ".ready_cycles"}, ready_cnt, exp_ready);
        check({tag, ".done_pulses"}, done_cnt, exp_done);
        check({tag, ".err_pulses"}, err_cnt, exp_err);
        check({tag, ".done_position"}, done_at, (exp_done != 0) ? exp_tx : -1);
        check({tag, ".done_err_overlap"}, both_cnt, 0);
        check({tag, ".ifg_cycles"}, ifg_cnt, IFG);

        build_expected(dst, et, (exp_err != 0) ? exp_ready - 1 : n_pay);
        cmp_len = (exp_err != 0) ? 44 + exp_ready - 1 : exp_q.size();
        for (int i = 0; i < cmp_len; i++) begin
            if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) begin
                mism = i;
                break;
            end
        end
        check({tag, ".first_bad_nibble"}, mism, -1);
        if (exp_err == 0) check({tag, ".crc_residue"}, residue(), 32'hDEBB20E3);
        $display("frame %s: payload=%0d tx_nibbles=%0d ready=%0d done=%0d err=%0d",
                 tag, n_pay, cap_q.size(), ready_cnt, done_cnt, err_cnt);
    endtask

    initial begin
        int n;
        logic [47:0] d;
        logic [15:0] t;

        vecs[0] = '{48'hFFFFFFFFFFFF, 16'h0806,    8, -1, -1, 1'b1,  144,    8, 1, 0};
        vecs[1] = '{48'h0123456789AB, 16'h0800,  200, -1, -1, 1'b0,  252,  200, 1, 0};
        vecs[2] = '{48'hA0B1C2D3E4F5, 16'h86DD,   92, -1, -1, 1'b0,  144,   92, 1, 0};
        vecs[3] = '{48'h5A5A5A5A5A5A, 16'h0806,   93, -1, -1, 1'b0,  146,   93, 1, 0};
        vecs[4] = '{48'h000000000001, 16'h1234,    1, -1, -1, 1'b0,  144,    1, 1, 0};
        vecs[5] = '{48'hDEADBEEF0001, 16'h0800,   20,  9, -1, 1'b0,   54,   10, 0, 1};
        vecs[6] = '{48'hCAFEF00D1234, 16'h0800, 3002, -1, 20, 1'b0, 3045, 3001, 0, 1};
        vecs[7] = '{48'h112233445566, 16'h0806,   16,  0, -1, 1'b0,   45,    1, 0, 1};

        rst       = 1'b1;
        start     = 1'b0;
        din       = 4'h0;
        din_valid = 1'b0;
        din_last  = 1'b0;
        dst_mac   = 48'h0;
        ethertype = 16'h0;

        // Reset state, with a start request held under reset.
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {txd, txctl, din_ready, busy, done, err}, 0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;

        for (int r = 0; r < 8; r++) begin
            pay_q.delete();
            for (int i = 0; i < vecs[r].n_pay; i++)
                pay_q.push_back(vecs[r].counting ? 4'(i + 1) : 4'($urandom));
            repeat (3) @(negedge clk);
            run_frame($sformatf("vec%0d", r), vecs[r].dst, vecs[r].et, vecs[r].n_pay,
                      vecs[r].underrun_at, vecs[r].inject_at, vecs[r].exp_tx,
                      vecs[r].exp_ready, vecs[r].exp_done, vecs[r].exp_err);
            if (vecs[r].inject_at >= 0) begin
                repeat (3) @(negedge clk);
                #1;
                check("ignored_start_not_queued", {busy, txctl}, 2'b00);
            end
        end

        // Reset in the middle of the DA field.
        @(negedge clk);
        dst_mac   = {$urandom, 16'($urandom)};
        ethertype = 16'h0806;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #1;
        check("mid_da.txctl", {txctl, din_ready, busy}, 3'b101);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_da.reset_next", {txctl, busy, done, err}, 4'b0000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("mid_da.no_ifg", {busy, txctl}, 2'b00);
        $display("frame reset_mid_da: txctl=%0d busy=%0d after reset", txctl, busy);

        // Randomized frames against the reference model.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 160);
            d = {$urandom, 16'($urandom)};
            t = 16'($urandom);
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(4'($urandom));
            repeat ($urandom_range(1, 4)) @(negedge clk);
            run_frame($sformatf("rand%0d", r), d, t, n, -1, -1,
                      44 + ((n + n % 2) < 92 ? 92 : (n + n % 2)) + 8, n, 1, 0);
        end

        // Back-to-back: second start on the first cycle busy is low.
        pay_q.delete();
        for (int i = 0; i < 30; i++) pay_q.push_back(4'($urandom));
        @(negedge clk);
        run_frame("b2b_a", 48'h020000000001, 16'h0806, 30, -1, -1, 144, 30, 1, 0);
        pay_q.delete();
        for (int i = 0; i < 120; i++) pay_q.push_back(4'($urandom));
        run_frame("b2b_b", 48'h020000000002, 16'h0800, 120, -1, -1, 172, 120, 1, 0);
        check("b2b.gap_at_least_ifg", (last_gap >= IFG) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
